// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM host-port arbiter.
package sdram_arb_pkg;

  localparam int unsigned DefNumPorts = 2;
  localparam int unsigned DefAddrW    = 24;
  localparam int unsigned DefDataW    = 16;
  localparam int unsigned DefStartTmo = 15;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StComplete
  } arb_state_e;

  // Index width that stays legal for a single-port build.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_host_arbiter_if.sv
// Client request bus plus controller host port seen by the arbiter.
interface sdram_host_arbiter_if #(
  parameter int unsigned NUM_PORTS = sdram_arb_pkg::DefNumPorts,
  parameter int unsigned ADDR_W    = sdram_arb_pkg::DefAddrW,
  parameter int unsigned DATA_W    = sdram_arb_pkg::DefDataW
);
  localparam int unsigned IdxW = sdram_arb_pkg::idx_width(NUM_PORTS);

  // Client side
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS-1:0]        req_we;
  logic [NUM_PORTS*ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0]        req_ack;
  logic                        req_err;
  logic [DATA_W-1:0]           rd_data;
  logic [IdxW-1:0]             grant_id;

  // Controller side
  logic [ADDR_W-1:0]           haddr;
  logic [DATA_W-1:0]           data_input;
  logic                        rd_enable;
  logic                        wr_enable;
  logic                        busy;
  logic [DATA_W-1:0]           data_output;

  // Arbiter view
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, busy, data_output,
    output req_ack, req_err, rd_data, grant_id, haddr, data_input, rd_enable, wr_enable
  );

  // Clients plus controller view
  modport master (
    output req_valid, req_we, req_addr, req_wdata, busy, data_output,
    input  req_ack, req_err, rd_data, grant_id, haddr, data_input, rd_enable, wr_enable
  );

endinterface

// File: rtl/sdram_rr_picker.sv
// Combinational round-robin pick: first requester at or above the pointer, with wrap.
module sdram_rr_picker #(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned IdxW      = 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IdxW-1:0]      ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IdxW-1:0]      idx_o,
  output logic                 any_o
);

  // Scan candidates in priority order starting at the pointer; first hit wins.
  always_comb begin
    logic [IdxW-1:0] cand;
    cand  = '0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NUM_PORTS);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Shares the single sdram_controller host port between NUM_PORTS clients.
// Round-robin grant, one transaction in flight, start timeout when busy never rises.
module sdram_host_arbiter import sdram_arb_pkg::*; #(
  parameter int unsigned NUM_PORTS = DefNumPorts,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned START_TMO = DefStartTmo
) (
  input logic                 clk,
  input logic                 rst_n,
  sdram_host_arbiter_if.slave host_io
);

  localparam int unsigned IdxW = idx_width(NUM_PORTS);
  localparam int unsigned CntW = $clog2(START_TMO + 1);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      grant_id_q, grant_id_d;
  logic [NUM_PORTS-1:0] owner_q, owner_d;
  logic                 op_q, op_d;  // 1 = write
  logic [ADDR_W-1:0]    haddr_q, haddr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [NUM_PORTS-1:0] pick_oh;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;

  sdram_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IdxW      (IdxW)
  ) u_picker (
    .req_i (host_io.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Mux the picked port's request fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (pick_oh[p]) begin
        sel_we    = host_io.req_we[p];
        sel_addr  = host_io.req_addr[p*ADDR_W +: ADDR_W];
        sel_wdata = host_io.req_wdata[p*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic for the transaction FSM and its latches.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    owner_d    = owner_q;
    op_d       = op_q;
    haddr_d    = haddr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    unique case (state_q)
      StIdle: begin
        // Controller busy (init/refresh) blocks any new grant.
        if (!host_io.busy && pick_any) begin
          state_d    = StIssue;
          grant_id_d = pick_idx;
          owner_d    = pick_oh;
          op_d       = sel_we;
          haddr_d    = sel_addr;
          wdata_d    = sel_wdata;
          cnt_d      = '0;
          err_d      = 1'b0;
        end
      end
      StIssue: begin
        if (host_io.busy) begin
          state_d = StWaitDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntW'(START_TMO)) begin
            state_d = StComplete;
            err_d   = 1'b1;
          end
        end
      end
      StWaitDone: begin
        if (!host_io.busy) begin
          if (!op_q) begin
            rd_data_d = host_io.data_output;
          end
          state_d = StComplete;
        end
      end
      StComplete: begin
        ptr_d   = (grant_id_q == IdxW'(NUM_PORTS - 1)) ? '0 : grant_id_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latch registers; reset aborts any transaction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      grant_id_q <= '0;
      owner_q    <= '0;
      op_q       <= 1'b0;
      haddr_q    <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      owner_q    <= owner_d;
      op_q       <= op_d;
      haddr_q    <= haddr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Decode enables and the completion pulse from registered state only.
  always_comb begin
    host_io.rd_enable = (state_q == StIssue) && !op_q;
    host_io.wr_enable = (state_q == StIssue) && op_q;
    host_io.req_ack   = (state_q == StComplete) ? owner_q : '0;
    host_io.req_err   = (state_q == StComplete) && err_q;
  end

  assign host_io.rd_data    = rd_data_q;
  assign host_io.grant_id   = grant_id_q;
  assign host_io.haddr      = haddr_q;
  assign host_io.data_input = wdata_q;

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Bench for sdram_host_arbiter: behavioural controller model, random and directed
// clients, and a scoreboard monitor that checks every completion.
module tb_sdram_host_arbiter;
  localparam int unsigned NP  = 2;
  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_host_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_host_arbiter #(
    .NUM_PORTS (NP),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .START_TMO (TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .host_io (bus)
  );

  typedef struct {
    int            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            err;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents before anything is written
  function automatic logic [DW-1:0] def_val(logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'hC3A5;
  endfunction

  // ---------------- controller model: busy rises 2 cycles after enable, stays 4
  logic [DW-1:0] mem_m[logic [AW-1:0]];
  bit            stall = 1'b0;
  bit            m_act;
  int            m_cnt, init_cnt, en_len, en_first_cyc, fall_cyc;
  bit            cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;

  initial begin
    bus.busy        = 1'b1;
    bus.data_output = '0;
    m_act           = 1'b0;
    init_cnt        = 20;
    en_len          = 0;
    forever begin
      bit en;
      @(negedge clk);
      en = bus.rd_enable || bus.wr_enable;
      if (!rst_n) begin
        bus.busy = 1'b1;
        m_act    = 1'b0;
        init_cnt = 20;
      end else if (init_cnt > 0) begin
        init_cnt--;
        if (init_cnt == 0) bus.busy = 1'b0;
      end else begin
        if (!m_act && en) begin
          m_act        = 1'b1;
          m_cnt        = 0;
          en_len       = 0;
          en_first_cyc = cyc;
          cap_we       = bus.wr_enable;
          cap_addr     = bus.haddr;
          cap_wdata    = bus.data_input;
        end else if (m_act) begin
          if (stall) begin
            if (!en) m_act = 1'b0;
          end else begin
            m_cnt++;
            if (m_cnt == 1) begin
              bus.busy = 1'b1;
            end else if (m_cnt == 5) begin
              bus.busy = 1'b0;
              fall_cyc = cyc;
              m_act    = 1'b0;
              if (cap_we) mem_m[cap_addr] = cap_wdata;
              else bus.data_output = mem_m.exists(cap_addr) ? mem_m[cap_addr] : def_val(cap_addr);
            end
          end
        end
        if (en) en_len++;
      end
    end
  end

  // ---------------- scoreboard monitor with a reference memory
  logic [DW-1:0] ref_mem[logic [AW-1:0]];

  function automatic int rr_pick(bit [NP-1:0] s, int last);
    for (int i = 1; i <= NP; i++) begin
      int c;
      c = (last + i) % NP;
      if (s[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit [NP-1:0] pend_mask();
    bit [NP-1:0] m;
    m = '0;
    foreach (sb_q[i]) m[sb_q[i].port] = 1'b1;
    return m;
  endfunction

  initial begin
    int            last_port;
    bit [NP-1:0]   pend_prev, grant_set;
    bit            en_prev;
    logic [DW-1:0] exp_rd;
    last_port = NP - 1;
    pend_prev = '0;
    grant_set = '0;
    en_prev   = 1'b0;
    exp_rd    = '0;
    forever begin
      bit en;
      @(negedge clk);
      if (!rst_n) begin
        last_port = NP - 1;
        pend_prev = '0;
        en_prev   = 1'b0;
        exp_rd    = '0;
        continue;
      end
      en = bus.rd_enable || bus.wr_enable;
      check("single_enable", 32'(bus.rd_enable && bus.wr_enable), 0);
      // Grant happened at the previous edge; pending set was what we held then.
      if (en && !en_prev) grant_set = pend_prev;
      en_prev = en;
      if (bus.req_ack != '0) begin
        int p, idx;
        p = -1;
        for (int i = NP - 1; i >= 0; i--) if (bus.req_ack[i]) p = i;
        check("ack_onehot", $countones(bus.req_ack), 1);
        check("rr_order", p, rr_pick(grant_set, last_port));
        check("grant_id", 32'(bus.grant_id), p);
        idx = -1;
        foreach (sb_q[i]) if (idx < 0 && sb_q[i].port == p) idx = i;
        check("ack_expected", 32'(idx >= 0), 1);
        if (idx >= 0) begin
          exp_t e;
          e = sb_q[idx];
          sb_q.delete(idx);
          check("req_err", 32'(bus.req_err), 32'(e.err));
          check("op", 32'(cap_we), 32'(e.we));
          check("haddr", 32'(cap_addr), 32'(e.addr));
          if (e.we) check("data_input", 32'(cap_wdata), 32'(e.wdata));
          check("enable_cycles", en_len, e.err ? TMO : 2);
          if (!e.err) begin
            if (e.we) ref_mem[e.addr] = e.wdata;
            else exp_rd = ref_mem.exists(e.addr) ? ref_mem[e.addr] : def_val(e.addr);
            check("ack_latency", cyc - fall_cyc, 1);
          end
          check("rd_data", 32'(bus.rd_data), 32'(exp_rd));
        end
        last_port = p;
      end
      pend_mask_upd: pend_prev = pend_mask();
    end
  end

  // ---------------- stimulus
  bit [NP-1:0]   active = '0, hidden = '0, hide_on_en = '0;
  bit            a_we[NP];
  logic [AW-1:0] a_addr[NP];
  logic [DW-1:0] a_wdata[NP];
  bit            en_seen;

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      bus.req_valid[p]             = active[p] && !hidden[p];
      bus.req_we[p]                = a_we[p];
      bus.req_addr[p*AW +: AW]     = a_addr[p];
      bus.req_wdata[p*DW +: DW]    = a_wdata[p];
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.rd_enable || bus.wr_enable) begin
      en_seen = 1'b1;
      hidden  = hidden | hide_on_en;
    end
    for (int p = 0; p < NP; p++) begin
      if (bus.req_ack[p]) begin
        active[p]     = 1'b0;
        hidden[p]     = 1'b0;
        hide_on_en[p] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic issue(int p, bit we, logic [AW-1:0] addr, logic [DW-1:0] wd);
    active[p]  = 1'b1;
    a_we[p]    = we;
    a_addr[p]  = addr;
    a_wdata[p] = wd;
    sb_q.push_back('{port: p, we: we, addr: addr, wdata: wd, err: stall});
    drive();
  endtask

  task automatic wait_all(int budget, string name);
    int n;
    n = 0;
    while (active != '0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_completed"}, 32'(active), 0);
  endtask

  task automatic check_zero_outputs(string tag);
    check({tag, "_req_ack"},    32'(bus.req_ack), 0);
    check({tag, "_req_err"},    32'(bus.req_err), 0);
    check({tag, "_rd_enable"},  32'(bus.rd_enable), 0);
    check({tag, "_wr_enable"},  32'(bus.wr_enable), 0);
    check({tag, "_rd_data"},    32'(bus.rd_data), 0);
    check({tag, "_grant_id"},   32'(bus.grant_id), 0);
    check({tag, "_haddr"},      32'(bus.haddr), 0);
    check({tag, "_data_input"}, 32'(bus.data_input), 0);
  endtask

  task automatic random_traffic(int cycles, int prob_den);
    for (int n = 0; n < cycles; n++) begin
      step();
      for (int p = 0; p < NP; p++) begin
        if (!active[p] && $urandom_range(0, prob_den - 1) == 0)
          issue(p, 1'($urandom_range(0, 1)), AW'(24'h100 + $urandom_range(0, 7)), DW'($urandom));
      end
    end
  endtask

  initial begin
    int rc, n;
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      a_we[p]    = 1'b0;
      a_addr[p]  = '0;
      a_wdata[p] = '0;
    end
    drive();
    mem_m[24'h00ABCD]   = 16'h5A5A;
    ref_mem[24'h00ABCD] = 16'h5A5A;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");

    // Controller busy after reset blocks the pending read
    rst_n = 1'b1;
    issue(0, 1'b0, 24'h000010, '0);
    en_seen = 1'b0;
    repeat (18) step();
    check("no_grant_while_busy", 32'(en_seen), 0);
    wait_all(100, "init_read");

    // Single write: request-to-enable latency and latched bus values
    step();
    rc = cyc;
    issue(0, 1'b1, 24'h000123, 16'hBEEF);
    wait_all(50, "write0");
    check("req_to_enable", en_first_cyc - rc, 1);

    // Port 1 read of a preloaded location, then a write that must not touch rd_data
    step();
    issue(1, 1'b0, 24'h00ABCD, '0);
    wait_all(50, "read1");
    step();
    issue(0, 1'b1, 24'h000200, 16'h1357);
    wait_all(50, "write_keeps_rd");

    // Both ports requesting back-to-back
    random_traffic(80, 1);
    wait_all(100, "contention");

    // Owner drops req_valid once its transaction is on the bus
    step();
    hide_on_en[1] = 1'b1;
    issue(1, 1'b1, 24'h000300, 16'hA5A5);
    wait_all(50, "drop_valid");

    // Start timeout: write is dropped, following read sees old contents
    step();
    stall = 1'b1;
    issue(0, 1'b1, 24'h000777, 16'h1234);
    wait_all(60, "timeout");
    stall = 1'b0;
    step();
    issue(0, 1'b0, 24'h000777, '0);
    wait_all(50, "after_timeout");

    // Random mixed traffic
    random_traffic(400, 3);
    wait_all(100, "random");

    // Reset while waiting for the controller to finish
    step();
    issue(1, 1'b0, 24'h000101, '0);
    n = 0;
    while (!(m_act && bus.busy) && n < 30) begin
      step();
      n++;
    end
    check("reached_wait_done", 32'(m_act && bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    sb_q.delete();
    active = '0;
    hidden = '0;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Both pending at once after reset: pointer restarts at port 0
    issue(1, 1'b0, 24'h000104, '0);
    issue(0, 1'b0, 24'h000105, '0);
    wait_all(200, "post_reset");
    repeat (3) step();
    check("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
